// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready register chain with bubble collapsing.
// Optional stall-cycle counter enabled by defining PIPE_REG_STALL_CNT_EN.
//
// Handshake: a word moves across an interface on a rising edge only when
// valid and ready are both high in that cycle. A valid offer is held stable
// until it is taken. Ready may depend combinationally on the downstream
// ready, never on the upstream valid.
module pipe_reg_chain #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occ
`ifdef PIPE_REG_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] rdy;
  logic             rdy_acc;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OW-1:0]    occ_q, occ_d;

  // Stage ready chain: a stage can accept if it is empty or its successor accepts.
  always_comb begin
    rdy            = '0;
    rdy_acc        = !v_q[DEPTH-1] || out_ready;
    rdy[DEPTH-1]   = rdy_acc;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy_acc = !v_q[i] || rdy_acc;
      rdy[i]  = rdy_acc;
    end
  end

  assign in_ready  = rst && en && !flush && rdy[0];
  assign out_valid = en && v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occ       = occ_q;

  // Next-state for valid bits and data: flush wins, en=0 holds everything.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) data_d[i] = data_q[i];
    if (flush) begin
      v_d = '0;
      for (int i = 0; i < DEPTH; i++) data_d[i] = RESET_VAL;
    end else if (en) begin
      if (rdy[0]) begin
        v_d[0] = in_valid;
        if (in_valid) data_d[0] = in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) data_d[i] = data_q[i-1];
        end
      end
    end
  end

  // Occupancy is registered alongside the valid bits so it always matches them.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + OW'(v_d[i]);
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end

`ifdef PIPE_REG_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Count cycles where a word is offered but not taken; saturates, ignores flush.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Testbench for pipe_reg_chain (WIDTH=32, DEPTH=2, non-zero RESET_VAL).
// Define PIPE_REG_STALL_CNT_EN to also exercise the stall counter.
module tb_pipe_reg_chain;
  localparam int          WIDTH = 32;
  localparam int          DEPTH = 2;
  localparam int          OW    = $clog2(DEPTH+1);
  localparam logic [31:0] RV    = 32'hC0DE_0000;

  logic              clk, rst, en, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0]  in_data, out_data;
  logic [OW-1:0]     occ;
`ifdef PIPE_REG_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occ       (occ)
`ifdef PIPE_REG_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, flush, iv;
    logic [31:0] id;
    logic        ordy;
    logic        ir, ov;
    logic [31:0] od;
    int          occ;
  } vec_t;

  vec_t tbl [26];

  int n_cmp, n_bad, n_out;

  // Reference model: words in arrival order (oldest first) with stage positions.
  int          m_pos [$];
  logic [31:0] m_dat [$];
  logic [31:0] m_last;
  logic [31:0] m_stall;
  logic [31:0] exp_q [$];

  function automatic vec_t mk(logic r, logic e, logic f, logic v, logic [31:0] d, logic o,
                              logic ir, logic ov, logic [31:0] od, int oc);
    vec_t t;
    t.rst = r; t.en = e; t.flush = f; t.iv = v; t.id = d; t.ordy = o;
    t.ir = ir; t.ov = ov; t.od = od; t.occ = oc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos.delete(); m_dat.delete(); exp_q.delete();
    m_last  = RV;
    m_stall = '0;
  endtask

  // One clock cycle: drive, check against model (and table row if row>=0), advance model.
  task automatic cycle(input logic r, input logic e, input logic f, input logic v,
                       input logic [31:0] d, input logic o, input int row);
    logic        x_ir, x_ov;
    int          p, q, prev;
    int          np [$];
    logic [31:0] nd [$];
    @(negedge clk);
    rst = r; en = e; flush = f; in_valid = v; in_data = d; out_ready = o;
    #1;
    x_ir = r && e && !f && ((m_pos.size() < DEPTH) || o);
    x_ov = e && (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
    chk("in_ready",  32'(in_ready),  32'(x_ir));
    chk("out_valid", 32'(out_valid), 32'(x_ov));
    chk("out_data",  out_data,       m_last);
    chk("occ",       32'(occ),       32'(m_pos.size()));
`ifdef PIPE_REG_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    if (row >= 0) begin
      chk($sformatf("tbl%0d_in_ready", row),  32'(in_ready),  32'(tbl[row].ir));
      chk($sformatf("tbl%0d_out_valid", row), 32'(out_valid), 32'(tbl[row].ov));
      chk($sformatf("tbl%0d_out_data", row),  out_data,       tbl[row].od);
      chk($sformatf("tbl%0d_occ", row),       32'(occ),       32'(tbl[row].occ));
    end
    if (x_ov && o) begin
      n_out++;
      if (exp_q.size() > 0) chk("sb_order", out_data, exp_q.pop_front());
      else begin
        n_cmp++; n_bad++;
        $display("FAIL sb_order: got %h expected no output at t=%0t", out_data, $time);
      end
    end
    @(posedge clk);
    if (!r) model_reset();
    else begin
      if (x_ov && !o && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
      if (f) begin
        m_pos.delete(); m_dat.delete(); exp_q.delete();
        m_last = RV;
      end else if (e) begin
        prev = DEPTH + 1;
        foreach (m_pos[k]) begin
          p = m_pos[k];
          if (p == DEPTH - 1) begin
            if (o) continue;
            np.push_back(p); nd.push_back(m_dat[k]); prev = p;
          end else begin
            q = (p + 1 != prev) ? p + 1 : p;
            if (q == DEPTH - 1) m_last = m_dat[k];
            np.push_back(q); nd.push_back(m_dat[k]); prev = q;
          end
        end
        if (x_ir && v) begin
          np.push_back(0); nd.push_back(d); exp_q.push_back(d);
          if (DEPTH == 1) m_last = d;
        end
        m_pos = np; m_dat = nd;
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_out = 0;
    rst = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //            rst en fl iv  id            ordy ir ov od            occ
    tbl[0]  = mk(0, 1, 0, 1, 32'hDEADBEEF, 1,   0, 0, RV,           0);
    tbl[1]  = mk(1, 1, 0, 1, 32'hDEADBEEF, 1,   1, 0, RV,           0);
    tbl[2]  = mk(1, 1, 0, 0, 32'h0,        1,   1, 0, RV,           1);
    tbl[3]  = mk(1, 1, 0, 0, 32'h0,        1,   1, 1, 32'hDEADBEEF, 1);
    tbl[4]  = mk(1, 1, 0, 0, 32'h0,        1,   1, 0, 32'hDEADBEEF, 0);
    tbl[5]  = mk(1, 1, 0, 1, 32'hA,        0,   1, 0, 32'hDEADBEEF, 0);
    tbl[6]  = mk(1, 1, 0, 1, 32'hB,        0,   1, 0, 32'hDEADBEEF, 1);
    tbl[7]  = mk(1, 1, 0, 0, 32'h0,        0,   0, 1, 32'hA,        2);
    tbl[8]  = mk(1, 1, 0, 1, 32'hC,        1,   1, 1, 32'hA,        2);
    tbl[9]  = mk(1, 1, 0, 0, 32'h0,        0,   0, 1, 32'hB,        2);
    tbl[10] = mk(1, 1, 1, 1, 32'h55,       0,   0, 1, 32'hB,        2);
    tbl[11] = mk(1, 1, 0, 0, 32'h0,        1,   1, 0, RV,           0);
    tbl[12] = mk(1, 1, 0, 1, 32'h77,       0,   1, 0, RV,           0);
    tbl[13] = mk(1, 0, 0, 1, 32'h99,       1,   0, 0, RV,           1);
    tbl[14] = mk(1, 0, 0, 1, 32'h99,       1,   0, 0, RV,           1);
    tbl[15] = mk(1, 0, 0, 1, 32'h99,       1,   0, 0, RV,           1);
    tbl[16] = mk(1, 1, 0, 0, 32'h0,        0,   1, 0, RV,           1);
    tbl[17] = mk(1, 0, 0, 1, 32'h99,       1,   0, 0, 32'h77,       1);
    tbl[18] = mk(1, 1, 0, 0, 32'h0,        1,   1, 1, 32'h77,       1);
    tbl[19] = mk(1, 1, 0, 0, 32'h0,        1,   1, 0, 32'h77,       0);
    tbl[20] = mk(1, 1, 0, 1, 32'h11,       0,   1, 0, 32'h77,       0);
    tbl[21] = mk(1, 0, 1, 0, 32'h0,        0,   0, 0, 32'h77,       1);
    tbl[22] = mk(1, 1, 0, 0, 32'h0,        0,   1, 0, RV,           0);
    tbl[23] = mk(1, 1, 0, 1, 32'h22,       0,   1, 0, RV,           0);
    tbl[24] = mk(0, 1, 1, 1, 32'h33,       0,   0, 0, RV,           1);
    tbl[25] = mk(1, 1, 0, 0, 32'h0,        1,   1, 0, RV,           0);

    // Reset block
    repeat (2) @(posedge clk);
    model_reset();

    // Directed table
    for (int i = 0; i < 26; i++)
      cycle(tbl[i].rst, tbl[i].en, tbl[i].flush, tbl[i].iv, tbl[i].id, tbl[i].ordy, i);

    // Back-to-back stream 1..8 with out_ready held high
    n_out = 0;
    for (int i = 1; i <= 8; i++) cycle(1, 1, 0, 1, 32'(i), 1, -1);
    repeat (4) cycle(1, 1, 0, 0, 32'h0, 1, -1);
    chk("stream_count", 32'(n_out), 32'd8);

`ifdef PIPE_REG_STALL_CNT_EN
    // Stall counter: five offered-but-refused cycles, then reset
    cycle(0, 1, 0, 0, 32'h0, 0, -1);
    cycle(1, 1, 0, 1, 32'hABCD, 0, -1);
    cycle(1, 1, 0, 0, 32'h0, 0, -1);
    repeat (5) cycle(1, 1, 0, 0, 32'h0, 0, -1);
    #1 chk("stall_5", stall_cnt, 32'd5);
    cycle(0, 1, 0, 0, 32'h0, 0, -1);
    #1 chk("stall_clr", stall_cnt, 32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 32: bits per data word.
REQ-002 Parameter DEPTH, default 2, legal 1..8: number of register stages.
REQ-003 Parameter RESET_VAL, default 0 (WIDTH bits): value loaded into every data register on reset or flush.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset is synchronous and active-low.
REQ-006 Port en, input, 1: global advance enable; 0 freezes the whole chain.
REQ-007 Port flush, input, 1: synchronous kill of all in-flight words.
REQ-008 Port in_valid, input, 1: upstream word present.
REQ-009 Port in_data, input, WIDTH: upstream word.
REQ-010 Port in_ready, output, 1: chain accepts the word this cycle.
REQ-011 Port out_valid, output, 1: last stage holds a word offered downstream.
REQ-012 Port out_data, output, WIDTH: last-stage data register.
REQ-013 Port out_ready, input, 1: downstream accepts the word.
REQ-014 Port occ, output, $clog2(DEPTH+1): number of valid stages.
REQ-015 Port stall_cnt, output, 32: stall-cycle counter (present only per REQ-033).

Function
REQ-016 Each stage i (0 = input side, DEPTH-1 = output side) SHALL hold a WIDTH data register and a valid bit.
REQ-017 Stage ready: rdy[DEPTH-1] = !v[DEPTH-1] || out_ready; rdy[i] = !v[i] || rdy[i+1]; combinational, bubble-collapsing.
REQ-018 in_ready SHALL equal en && !flush && rdy[0].
REQ-019 out_valid SHALL equal en && v[DEPTH-1]; out_data SHALL always be the stage DEPTH-1 register.
REQ-020 Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-021 With en=1, flush=0: stage i loads stage i-1 (stage 0 loads in_data) when rdy[i]; its valid bit takes the source valid (in_valid for stage 0); otherwise the stage holds.
REQ-022 A stage whose source is not valid SHALL keep its data register unchanged and clear its valid bit.
REQ-023 Latency: a word entering an empty chain SHALL appear on out_valid exactly DEPTH cycles after its input transfer, with no stalls.
REQ-024 Throughput: with out_ready held 1 and in_valid held 1, one word per cycle SHALL transfer in and out, order preserved, no loss or duplication.
REQ-025 Full chain with out_ready=0: in_ready=0, all stages hold; simultaneous out_ready=1 and in_valid=1 SHALL shift all stages and accept the new word in the same cycle.
REQ-026 en=0: no stage loads, no transfer, all registers and valid bits hold, regardless of in_valid/out_ready.
REQ-027 flush=1 (with rst=1): all valid bits SHALL clear and all data registers SHALL load RESET_VAL next cycle; the input word is not accepted; flush has priority over en.
REQ-028 occ SHALL be the registered population count of the valid bits (0..DEPTH).

Reset
REQ-029 rst=0 sampled at a rising edge SHALL clear every valid bit, load RESET_VAL into every data register, and zero stall_cnt.
REQ-030 During reset: in_ready=0, out_valid=0, occ=0, out_data=RESET_VAL from the first edge with rst low.
REQ-031 Reset SHALL override flush and en; words in flight at reset assertion are discarded.
REQ-032 The first input transfer SHALL be possible in the first cycle after rst returns high.

Configuration
REQ-033 Macro PIPE_REG_STALL_CNT_EN defined: stall_cnt increments by 1 each cycle with out_valid=1 && out_ready=0, saturates at 0xFFFFFFFF, clears on reset, and is unaffected by flush.
REQ-034 Macro PIPE_REG_STALL_CNT_EN undefined: the stall_cnt port and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 WIDTH=32, DEPTH=2, reset then in_valid=1, in_data=0xDEADBEEF, out_ready=1 for one cycle -> out_valid=1 with out_data=0xDEADBEEF exactly 2 cycles later, occ goes 0->1->1->0.
REQ-036 Stream 0x1..0x8 back-to-back with out_ready=1 -> outputs 0x1..0x8 in order on consecutive cycles, in_ready never drops.
REQ-037 Load 0xA, 0xB with out_ready=0 -> occ=2, in_ready=0; then out_ready=1 with in_valid=1, in_data=0xC -> 0xA output and 0xC accepted in the same cycle, occ stays 2.
REQ-038 occ=2, pulse flush=1 with in_valid=1, in_data=0x55 -> next cycle occ=0, out_valid=0, out_data=RESET_VAL, 0x55 never appears.
REQ-039 occ=1, en=0 for 3 cycles with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0, occ=1 held; en=1 resumes with the original word intact.
REQ-040 With PIPE_REG_STALL_CNT_EN defined, hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; rst low for one cycle -> stall_cnt=0.
